// File: rtl/cfs_rx_ctrl.sv
// RX controller: checks MD RX transfers for legality, pushes legal ones into
// the RX FIFO as {size, offset, data} and answers illegal ones with an error.
module cfs_rx_ctrl #(
    parameter int ALGN_DATA_WIDTH = 32,
    localparam int BYTES = ALGN_DATA_WIDTH / 8,
    localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(BYTES),
    localparam int ALGN_SIZE_WIDTH = $clog2(BYTES) + 1,
    localparam int FIFO_DATA_WIDTH = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         md_rx_valid,
    input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
    input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
    input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
    output logic                         md_rx_ready,
    output logic                         md_rx_err,
    output logic                         push_valid,
    output logic [FIFO_DATA_WIDTH-1:0]   push_data,
    input  logic                         push_ready,
    input  logic                         cnt_drop_clr,
    output logic [7:0]                   cnt_drop
);

    // One extra bit keeps offset+size and BYTES+offset from wrapping.
    localparam int SUMW = ALGN_SIZE_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, PUSH, RESP} state_t;

    state_t                       state, state_nxt;
    logic [SUMW-1:0]              off_ext, size_ext, end_sum, base_sum, divisor;
    logic                         legal;
    logic                         ready_d, err_d, pvalid_d;
    logic [FIFO_DATA_WIDTH-1:0]   pdata_d;
    logic [7:0]                   drop_d;

    always_comb begin
        off_ext  = SUMW'(md_rx_offset);
        size_ext = SUMW'(md_rx_size);
        end_sum  = off_ext + size_ext;
        base_sum = SUMW'(BYTES) + off_ext;
        divisor  = (size_ext == '0) ? SUMW'(1) : size_ext;
        legal    = (size_ext != '0) && (end_sum <= SUMW'(BYTES)) &&
                   ((base_sum % divisor) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            md_rx_ready <= 1'b0;
            md_rx_err   <= 1'b0;
            push_valid  <= 1'b0;
            push_data   <= '0;
            cnt_drop    <= '0;
        end else begin
            state       <= state_nxt;
            md_rx_ready <= ready_d;
            md_rx_err   <= err_d;
            push_valid  <= pvalid_d;
            push_data   <= pdata_d;
            cnt_drop    <= drop_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (md_rx_valid) state_nxt = legal ? PUSH : RESP;
            PUSH:    if (push_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        ready_d  = 1'b0;
        err_d    = 1'b0;
        pvalid_d = 1'b0;
        pdata_d  = push_data;
        drop_d   = cnt_drop;
        case (state)
            IDLE: begin
                if (md_rx_valid) begin
                    if (legal) begin
                        pvalid_d = 1'b1;
                        pdata_d  = {md_rx_size, md_rx_offset, md_rx_data};
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        if (cnt_drop != 8'hFF) drop_d = cnt_drop + 8'd1;
                    end
                end
            end
            PUSH: begin
                if (push_ready) ready_d = 1'b1;
                else            pvalid_d = 1'b1;
            end
            default: ;
        endcase
        if (cnt_drop_clr) drop_d = '0;
    end

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Randomized bench for cfs_rx_ctrl (W=32 and W=8 instances) against a
// transaction-level model of legality, timing and the drop counter.
module tb_cfs_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_ready;
    logic        cnt_drop_clr;

    logic        md_rx_valid;
    logic [31:0] md_rx_data;
    logic [1:0]  md_rx_offset;
    logic [2:0]  md_rx_size;
    logic        md_rx_ready, md_rx_err, push_valid;
    logic [36:0] push_data;
    logic [7:0]  cnt_drop;

    logic        v8;
    logic [7:0]  d8;
    logic [0:0]  off8, sz8;
    logic        rdy8, err8, pv8;
    logic [9:0]  pd8;
    logic [7:0]  cnt8;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    cfs_rx_ctrl #(.ALGN_DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
        .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size),
        .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .cnt_drop_clr(cnt_drop_clr), .cnt_drop(cnt_drop)
    );

    cfs_rx_ctrl #(.ALGN_DATA_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .md_rx_valid(v8), .md_rx_data(d8),
        .md_rx_offset(off8), .md_rx_size(sz8),
        .md_rx_ready(rdy8), .md_rx_err(err8),
        .push_valid(pv8), .push_data(pd8), .push_ready(push_ready),
        .cnt_drop_clr(cnt_drop_clr), .cnt_drop(cnt8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input int bytes, input int off, input int sz);
        if (sz == 0) return 1'b0;
        if (off + sz > bytes) return 1'b0;
        return ((bytes + off) % sz) == 0;
    endfunction

    // One full transfer on the W=32 instance, checked cycle by cycle.
    task automatic xfer(input int off, input int sz, input logic [31:0] d,
                        input int stall, input bit drop_vld, input bit clr);
        bit legal;
        logic [36:0] exp_pd;
        legal  = is_legal(4, off, sz);
        exp_pd = {3'(sz), 2'(off), d};
        md_rx_valid  = 1'b1;
        md_rx_offset = 2'(off);
        md_rx_size   = 3'(sz);
        md_rx_data   = d;
        push_ready   = (stall == 0);
        cnt_drop_clr = clr;
        tick();
        cnt_drop_clr = 1'b0;
        if (clr) exp_drop = 0;
        else if (!legal && exp_drop < 255) exp_drop++;
        chk("cnt_drop", 64'(cnt_drop), 64'(exp_drop));
        if (legal) begin
            chk("push_valid_c1", 64'(push_valid), 64'd1);
            chk("push_data_c1", 64'(push_data), 64'(exp_pd));
            chk("ready_c1", 64'(md_rx_ready), 64'd0);
            if (drop_vld) md_rx_valid = 1'b0;
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("push_valid_hold", 64'(push_valid), 64'd1);
                chk("push_data_hold", 64'(push_data), 64'(exp_pd));
                chk("ready_hold", 64'(md_rx_ready), 64'd0);
            end
            push_ready = 1'b1;
            tick();
            chk("push_valid_done", 64'(push_valid), 64'd0);
            chk("ready_resp", 64'(md_rx_ready), 64'd1);
            chk("err_resp", 64'(md_rx_err), 64'd0);
        end else begin
            chk("ready_err", 64'(md_rx_ready), 64'd1);
            chk("err_err", 64'(md_rx_err), 64'd1);
            chk("push_valid_err", 64'(push_valid), 64'd0);
        end
        md_rx_valid = 1'b0;
        push_ready  = 1'($urandom_range(0, 1));
        tick();
        chk("ready_idle", 64'(md_rx_ready), 64'd0);
        chk("err_idle", 64'(md_rx_err), 64'd0);
        chk("push_valid_idle", 64'(push_valid), 64'd0);
    endtask

    initial begin
        int exp8;
        reset = 1'b1;
        md_rx_valid = 1'b0; md_rx_data = '0; md_rx_offset = '0; md_rx_size = '0;
        v8 = 1'b0; d8 = '0; off8 = '0; sz8 = '0;
        push_ready = 1'b1; cnt_drop_clr = 1'b0;
        #3;
        chk("rst_ready", 64'(md_rx_ready), 64'd0);
        chk("rst_err", 64'(md_rx_err), 64'd0);
        chk("rst_pv", 64'(push_valid), 64'd0);
        chk("rst_pd", 64'(push_data), 64'd0);
        chk("rst_cnt", 64'(cnt_drop), 64'd0);
        #9 reset = 1'b0;

        // W=8: only offset 0 / size 1 is legal
        exp8 = 0;
        v8 = 1'b1; off8 = 1'b0; sz8 = 1'b1; d8 = 8'h5A;
        tick();
        chk("w8_pv", 64'(pv8), 64'd1);
        chk("w8_pd", 64'(pd8), 64'({1'b1, 1'b0, 8'h5A}));
        tick();
        chk("w8_ready", 64'(rdy8), 64'd1);
        chk("w8_err0", 64'(err8), 64'd0);
        v8 = 1'b0; tick();
        for (int k = 0; k < 2; k++) begin
            v8 = 1'b1; off8 = 1'(k); sz8 = 1'(k);
            tick();
            exp8++;
            chk("w8_bad_ready", 64'(rdy8), 64'd1);
            chk("w8_bad_err", 64'(err8), 64'd1);
            chk("w8_bad_pv", 64'(pv8), 64'd0);
            chk("w8_cnt", 64'(cnt8), 64'(exp8));
            v8 = 1'b0; tick();
        end

        // Directed W=32 cases
        xfer(1, 1, 32'hA5A5_1234, 0, 1'b0, 1'b0);
        xfer(1, 2, 32'h1111_2222, 0, 1'b0, 1'b0);
        xfer(0, 0, 32'h3333_4444, 0, 1'b0, 1'b0);
        xfer(2, 3, 32'h5555_6666, 0, 1'b0, 1'b0);
        chk("cnt_three", 64'(cnt_drop), 64'd3);
        xfer(0, 4, 32'hDEAD_BEEF, 5, 1'b0, 1'b0);
        xfer(2, 2, 32'hCAFE_F00D, 2, 1'b1, 1'b0);

        // Randomized transfers
        for (int n = 0; n < 80; n++)
            xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));

        // Saturation, then clear colliding with an increment
        for (int n = 0; n < 256; n++)
            xfer(1, 2, $urandom, 0, 1'b0, 1'b0);
        chk("cnt_sat", 64'(cnt_drop), 64'd255);
        xfer(0, 3, 32'h0, 0, 1'b0, 1'b1);
        chk("cnt_clr_win", 64'(cnt_drop), 64'd0);

        // Asynchronous reset while in PUSH
        md_rx_valid = 1'b1; md_rx_offset = 2'd0; md_rx_size = 3'd4; md_rx_data = 32'h0BAD_0BAD;
        push_ready = 1'b0;
        tick();
        chk("pre_rst_pv", 64'(push_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pv", 64'(push_valid), 64'd0);
        chk("mid_rst_ready", 64'(md_rx_ready), 64'd0);
        chk("mid_rst_pd", 64'(push_data), 64'd0);
        md_rx_valid = 1'b0;
        exp_drop = 0;
        #1 reset = 1'b0;
        tick();
        chk("post_rst_pv", 64'(push_valid), 64'd0);
        chk("post_rst_ready", 64'(md_rx_ready), 64'd0);
        xfer(3, 1, 32'h7777_8888, 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfs_rx_ctrl.md
# cfs_rx_ctrl

RX Controller for the aligner. It accepts transfers from the MD RX interface, checks each one for legality, and pushes legal transfers into the RX FIFO as packed {size, offset, data} entries. Illegal transfers are answered with an error response and counted, and nothing is written to the FIFO for them. It sits between the MD RX port and the RX FIFO push side. It is the receive-direction counterpart of the TX controller, which drains the TX FIFO onto the MD TX interface.

## Interface
- ALGN_DATA_WIDTH, 32: MD data width in bits; power of two, ≥8.
- Derived: BYTES = ALGN_DATA_WIDTH/8.
- Derived: ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH<=8) ? 1 : clog2(BYTES).
- Derived: ALGN_SIZE_WIDTH = clog2(BYTES)+1.
- Derived: FIFO_DATA_WIDTH = ALGN_DATA_WIDTH+ALGN_OFFSET_WIDTH+ALGN_SIZE_WIDTH.

Ports:
- clk  in  1  sole clock; everything sampled on rising edge.
- reset  in  1  asynchronous, active-high reset.
- md_rx_valid  in  1  master has a transfer pending.
- md_rx_data  in  ALGN_DATA_WIDTH  transfer data.
- md_rx_offset  in  ALGN_OFFSET_WIDTH  byte offset of first valid byte.
- md_rx_size  in  ALGN_SIZE_WIDTH  number of valid bytes.
- md_rx_ready  out  1  transfer completion strobe, one cycle long.
- md_rx_err  out  1  error flag; meaningful only while md_rx_ready=1.
- push_valid  out  1  FIFO write request.
- push_data  out  FIFO_DATA_WIDTH  packed entry: [W-1:0] data, next ALGN_OFFSET_WIDTH bits offset, top ALGN_SIZE_WIDTH bits size.
- push_ready  in  1  FIFO accepts the entry (push completes when push_valid&push_ready).
- cnt_drop_clr  in  1  synchronous clear of the drop counter.
- cnt_drop  out  8  saturating count of illegal transfers.

## Operation
- Legality rule, evaluated combinationally on the md_rx_* inputs:
  - size != 0
  - offset+size <= BYTES
  - (BYTES+offset) % size == 0
  - Sums are computed at ALGN_SIZE_WIDTH+1 bits so they never overflow.
- FSM states: IDLE, PUSH, RESP.
- IDLE:
  - If md_rx_valid=1 and the transfer is legal: capture data, offset and size into push_data, set push_valid=1, go to PUSH.
  - If md_rx_valid=1 and the transfer is illegal: set md_rx_ready=1 and md_rx_err=1 for the next cycle, increment cnt_drop, go to RESP.
  - If md_rx_valid=0: stay in IDLE.
- PUSH:
  - push_valid is held high and push_data is held stable until push_ready=1.
  - On the push handshake: push_valid→0 next cycle, md_rx_ready=1 and md_rx_err=0 next cycle, go to RESP.
- RESP: md_rx_ready is high for exactly this cycle; go to IDLE. md_rx_valid is ignored in RESP.
- The master holds md_rx_* stable until md_rx_ready. If md_rx_valid drops during PUSH, the push still completes and the response is still issued.
- cnt_drop saturates at 255. If cnt_drop_clr coincides with an increment, the clear wins and the increment is lost.

## Timing
- Reset values: state=IDLE, md_rx_ready=0, md_rx_err=0, push_valid=0, push_data=0, cnt_drop=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Legal transfer, FIFO not full:
  - cycle 0: valid sampled
  - cycle 1: push_valid=1, push_ready=1
  - cycle 2: md_rx_ready=1
  - cycle 3: IDLE, so a new valid is accepted at cycle 3 at the earliest.
  - Minimum latency from valid to ready is 2 cycles; throughput is one transfer per 3 cycles.
- FIFO full: each cycle with push_ready=0 in PUSH adds one cycle of latency. push_data must not change meanwhile.
- Illegal transfer: cycle 0 valid sampled → cycle 1 md_rx_ready=1, md_rx_err=1, cnt_drop already incremented → cycle 2 IDLE.
- md_rx_err=0 whenever md_rx_ready=0.
- Reset mid-operation, including in PUSH: all outputs return to reset values immediately (asynchronously). The in-flight transfer is abandoned with no push and no response.

## Test plan
- W=32, offset=1, size=1, data=0xA5A5_1234, push_ready=1 → push_data = {1, 1, 0xA5A5_1234} at cycle 1; md_rx_ready=1, err=0 at cycle 2.
- W=32, offset=1, size=2 → illegal (5%2≠0): md_rx_ready=1 with err=1 at cycle 1, no push_valid, cnt_drop=1. Repeat with size=0 and with offset=2, size=3 → cnt_drop=3.
- Legal offset=0, size=4 with push_ready held low for 5 cycles → push_valid and push_data stable for 6 cycles; md_rx_ready one cycle after push_ready rises.
- 256 back-to-back illegal transfers → cnt_drop sticks at 255. Assert cnt_drop_clr in the same cycle as an increment → 0.
- Assert reset during PUSH → push_valid and md_rx_ready drop immediately; after release a new legal transfer completes normally.
- W=8: only offset=0, size=1 is accepted; offset=0, size=0 → err.
